// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles,
// using a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full-subtractor cell on the current LSBs
  logic d_c;
  logic br_next_c;

  always_comb begin
    d_c       = a_q[0] ^ b_q[0] ^ br_q;
    br_next_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d = {d_c, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_next_c;
        bout_d = br_next_c;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=4.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       bin8, bin4;
  logic       busy8, done8, bout8;
  logic       busy4, done4, bout4;

  int n_checks;
  int n_fail;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         w;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic cur_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction

  function automatic logic cur_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction

  function automatic int cur_diff(input int w);
    return (w == 8) ? int'(diff8) : int'(diff4);
  endfunction

  function automatic int cur_bout(input int w);
    return (w == 8) ? int'(bout8) : int'(bout4);
  endfunction

  // Randomise the selected instance's operand inputs (must not affect a run)
  task automatic scramble(input int w);
    if (w == 8) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    end else begin
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    end
  endtask

  // One full operation with latency, pulse width, result and hold checks
  task automatic run_op(input vec_t v, input string nm);
    int  busy_cnt;
    bit  seen;
    @(negedge clk);
    if (v.w == 8) begin
      a8 = v.a; b8 = v.b; bin8 = v.bin; start8 = 1'b1;
    end else begin
      a4 = 4'(v.a); b4 = 4'(v.b); bin4 = v.bin; start4 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0;
    start4 = 1'b0;
    check({nm, "_clear_diff"}, cur_diff(v.w), 0);
    check({nm, "_clear_bout"}, cur_bout(v.w), 0);
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 3 * v.w + 4; i++) begin
      if (cur_done(v.w)) begin
        seen = 1'b1;
        break;
      end
      if (cur_busy(v.w)) busy_cnt++;
      scramble(v.w);
      @(negedge clk);
    end
    check({nm, "_done_seen"}, int'(seen), 1);
    check({nm, "_busy_cycles"}, busy_cnt, v.w);
    check({nm, "_busy_in_done"}, int'(cur_busy(v.w)), 0);
    check({nm, "_diff"}, cur_diff(v.w), int'(v.exp_diff));
    check({nm, "_bout"}, cur_bout(v.w), int'(v.exp_bout));
    @(negedge clk);
    check({nm, "_done_pulse"}, int'(cur_done(v.w)), 0);
    check({nm, "_diff_hold"}, cur_diff(v.w), int'(v.exp_diff));
  endtask

  vec_t vecs[12];
  int   done_cnt;
  int   last_done;
  int   gap_bad;
  bit   done_bad;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{8, 8'd200, 8'd55,  1'b0, 8'd145, 1'b0};
    vecs[1]  = '{8, 8'd5,   8'd10,  1'b0, 8'hFB,  1'b1};
    vecs[2]  = '{8, 8'd0,   8'd0,   1'b1, 8'hFF,  1'b1};
    vecs[3]  = '{8, 8'd30,  8'd12,  1'b1, 8'd17,  1'b0};
    vecs[4]  = '{8, 8'hAA,  8'h55,  1'b0, 8'h55,  1'b0};
    vecs[5]  = '{8, 8'd0,   8'd255, 1'b0, 8'd1,   1'b1};
    vecs[6]  = '{8, 8'd255, 8'd0,   1'b1, 8'd254, 1'b0};
    vecs[7]  = '{8, 8'd128, 8'd128, 1'b0, 8'd0,   1'b0};
    vecs[8]  = '{4, 8'd9,   8'd3,   1'b1, 8'd5,   1'b0};
    vecs[9]  = '{4, 8'd3,   8'd9,   1'b0, 8'hA,   1'b1};
    vecs[10] = '{4, 8'd0,   8'd0,   1'b1, 8'hF,   1'b1};
    vecs[11] = '{4, 8'd15,  8'd15,  1'b0, 8'd0,   1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0;
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(busy8), 0);
    check("rst_done", int'(done8), 0);
    check("rst_diff", int'(diff8), 0);
    check("rst_bout", int'(bout8), 0);
    check("rst_diff4", int'(diff4), 0);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start held high: one operation per WIDTH+2 cycles
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd1; bin8 = 1'b0; start8 = 1'b1;
    done_cnt = 0; last_done = -1; gap_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin
        done_cnt++;
        check("held_diff", int'(diff8), 99);
        check("held_bout", int'(bout8), 0);
        if (last_done >= 0 && (i - last_done) != 10) gap_bad++;
        last_done = i;
      end
    end
    check("held_done_count", done_cnt, 4);
    check("held_gap_errors", gap_bad, 0);
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    check("held_idle_busy", int'(busy8), 0);

    // Reset during RUN aborts without a done pulse
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("abort_busy_run", int'(busy8), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy8), 0);
    check("abort_diff", int'(diff8), 0);
    check("abort_bout", int'(bout8), 0);
    done_bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done8 || busy8) done_bad = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", int'(done_bad), 0);
    run_op(vecs[4], "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first multi-bit subtractor computing diff = a - b - bin over WIDTH clock cycles.
- Built from one full-subtractor cell (difference XOR and borrow logic) and a registered borrow flip-flop.
- It is the subtract-direction counterpart of the team's full-adder cell, for area-constrained datapaths.
- It sits between a requesting controller (start/busy/done handshake) and any consumer of the difference and borrow-out.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk   input   1      rising-edge clock
rst   input   1      synchronous active-high reset
start input   1      request; sampled only in IDLE
a     input   WIDTH  minuend; captured on accepted start
b     input   WIDTH  subtrahend; captured on accepted start
bin   input   1      borrow-in; captured on accepted start
busy  output  1      high while the operation is in progress
done  output  1      one-cycle pulse: result valid
diff  output  WIDTH  difference a - b - bin, modulo 2^WIDTH
bout  output  1      final borrow-out (1 when a < b + bin)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift registers, borrow register and counter cleared. Reset overrides every other input on the same edge.
- FSM states:
  - IDLE: start=1 at an edge loads a, b into the A/B shift registers, loads the borrow register from bin, sets count=0, and moves to RUN.
  - RUN: each edge processes bit x=A[0], y=B[0], br=borrow register:
    - d = x^y^br
    - br_next = (~x&y) | (~(x^y)&br)
    - d shifts into the MSB of the diff shift register; A and B shift right; count increments.
    - When count reaches WIDTH-1 on that edge, the next state is DONE.
  - DONE: lasts exactly one cycle with done=1, then returns to IDLE unconditionally.
- busy=1 exactly while in RUN (WIDTH cycles). done=1 only in DONE.
- Latency: start accepted at edge E → busy high for cycles E+1..E+WIDTH → done high in cycle E+WIDTH+1.
- diff and bout update only as bits are processed. They are valid from the done cycle and hold until the next accepted start, which clears diff and bout.
- start while in RUN or DONE is ignored; it is not queued. A new start is accepted at the first edge in IDLE.
  - Back-to-back throughput is therefore one operation per WIDTH+2 cycles.
- a, b, bin may change freely after capture; they have no effect until the next accepted start.
- Arithmetic: result equals (a - b - bin) mod 2^WIDTH, with bout as the borrow out of the MSB stage. There are no signed semantics.
- rst asserted mid-RUN aborts the operation: return to reset values, and no done pulse is produced.

Test Plan:
- WIDTH=8, a=200, b=55, bin=0, one start pulse → busy high 8 cycles, done at cycle 9; diff=145 (8'h91), bout=0.
- WIDTH=8, a=5, b=10, bin=0 → diff=8'hFB (251), bout=1. Then a=0, b=0, bin=1 → diff=8'hFF, bout=1.
- Start held high continuously with a=100, b=1, bin=0 → exactly one operation per 10 cycles; every done shows diff=99, bout=0. Extra start cycles during RUN/DONE produce no additional done pulses.
- a=8'hAA, b=8'h55, start; assert rst for one cycle at the 4th RUN cycle → done never pulses, busy drops the cycle after rst, diff=0, bout=0. A subsequent start of 8'hAA-8'h55 gives diff=8'h55, bout=0.
- Change a, b, bin every cycle during RUN after capturing a=30, b=12, bin=1 → diff=17, bout=0 (captured operands only).
- WIDTH=4 instance: a=9, b=3, bin=1 → busy 4 cycles, done at cycle 5, diff=5, bout=0. Then a=3, b=9, bin=0 → diff=4'hA, bout=1.
